tpu_rsqrt_iter_unit: RTL and testbench

TPU_RSQRT_ITER_UNIT -- requirements
Module: tpu_rsqrt_iter_unit

---
 rtl/tpu_rsqrt_iter_unit.sv | 259 +++++++++++++++++++++++++
 tb/tb_tpu_rsqrt_iter_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_rsqrt_iter_unit.sv
// tpu_rsqrt_iter_unit
//   Iterative reciprocal square root / square root of an unsigned fixed-point
//   operand. The operand is normalised by an even left shift into [0.25, 1),
//   seeded from an elaboration-time LUT, refined with Newton-Raphson steps,
//   optionally multiplied by m (sqrt), then rescaled and rounded.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   flush                  synchronous abort of the in-flight op
//   in_valid/in_ready      request handshake: in_data, in_op (0 rsqrt, 1 sqrt),
//                          in_iters (NR steps, clamped to MAX_ITERS), in_tag
//   out_valid/out_ready    result handshake: out_data, out_tag, out_sat, out_zero
//   busy                   unit not idle
//   ops_count, sat_count   completed / saturated result handshakes (wrap)
module tpu_rsqrt_iter_unit #(
  parameter int IN_WIDTH  = 16,
  parameter int IN_FRAC   = 8,
  parameter int OUT_WIDTH = 16,
  parameter int OUT_FRAC  = 11,
  parameter int LUT_BITS  = 6,
  parameter int MAX_ITERS = 3,
  parameter int TAG_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [IN_WIDTH-1:0]            in_data,
  input  logic                           in_op,
  input  logic [$clog2(MAX_ITERS+1)-1:0] in_iters,
  input  logic [TAG_WIDTH-1:0]           in_tag,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUT_WIDTH-1:0]           out_data,
  output logic [TAG_WIDTH-1:0]           out_tag,
  output logic                           out_sat,
  output logic                           out_zero,
  output logic                           busy,
  output logic [31:0]                    ops_count,
  output logic [31:0]                    sat_count
);
  localparam int IT_W = $clog2(MAX_ITERS+1);
  localparam int FB   = OUT_WIDTH + 2;          // fraction bits of r
  localparam int RW   = FB + 4;                 // integer headroom so r^2 near 4 cannot wrap
  localparam int NLUT = 1 << LUT_BITS;
  localparam int SW   = $clog2(IN_WIDTH + 1);
  localparam int WIDE = RW + IN_WIDTH + OUT_WIDTH;
  localparam logic [RW-1:0]        THREE  = RW'(3) << FB;
  localparam logic signed [15:0]   K_BASE = 16'(OUT_FRAC - FB);

  typedef enum logic [3:0] {
    S_IDLE, S_NORM, S_LUT, S_ITER_A, S_ITER_B, S_ITER_C, S_SQMUL, S_DENORM, S_DONE
  } state_t;

  // floor(sqrt(n)) by the digit-by-digit method
  function automatic logic [63:0] isqrt64(input logic [63:0] n);
    logic [63:0] v, res, bitv;
    v = n; res = '0; bitv = 64'h1 << 62;
    for (int k = 0; k < 32; k++) begin
      if (v >= res + bitv) begin
        v   = v - (res + bitv);
        res = (res >> 1) + bitv;
      end else begin
        res = res >> 1;
      end
      bitv = bitv >> 2;
    end
    return res;
  endfunction

  // seed[i] = round(2^FB / sqrt((i + 0.5) / 2^LUT_BITS))
  //         = round(sqrt(2^(2FB+LUT_BITS+1) / (2i+1))), rounded via floor(sqrt(4n))
  function automatic logic [NLUT*RW-1:0] build_seeds();
    logic [NLUT*RW-1:0] tbl;
    logic [63:0]        num, val;
    tbl = '0;
    for (int i = 0; i < NLUT; i++) begin
      num = (64'd1 << (2*FB + LUT_BITS + 1)) / 64'(2*i + 1);
      val = (isqrt64(num << 2) + 64'd1) >> 1;
      if (val >= (64'd1 << RW)) val = (64'd1 << RW) - 64'd1;
      tbl[i*RW +: RW] = val[RW-1:0];
    end
    return tbl;
  endfunction

  localparam logic [NLUT*RW-1:0] SEED_TBL = build_seeds();

  function automatic logic [SW-1:0] lzc(input logic [IN_WIDTH-1:0] v);
    logic [SW-1:0] c;
    logic          found;
    c = '0; found = 1'b0;
    for (int b = IN_WIDTH-1; b >= 0; b--) begin
      if (!found) begin
        if (v[b]) found = 1'b1;
        else      c = c + 1'b1;
      end
    end
    return c;
  endfunction

  state_t                 state_q, state_d;
  logic [IT_W-1:0]        iters_q, iters_d, left_q, left_d;
  logic                   op_q, op_d;
  logic [OUT_WIDTH-1:0]   out_data_q, out_data_d;
  logic [TAG_WIDTH-1:0]   out_tag_q, out_tag_d;
  logic                   out_sat_q, out_sat_d, out_zero_q, out_zero_d;
  logic [31:0]            ops_count_q, ops_count_d, sat_count_q, sat_count_d;

  logic [IN_WIDTH-1:0]    x_q, x_d, m_q, m_d;
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;
  logic [RW-1:0]          r_q, r_d, t_q, t_d;
  logic signed [7:0]      half_e_q, half_e_d;

  logic                   accept, out_hs;
  logic [SW-1:0]          lz, s_norm;
  logic [2*RW-1:0]        prod_rr, prod_rt;
  logic [IN_WIDTH+RW-1:0] prod_mt, prod_mr;
  logic [RW-1:0]          sq_r, mr2, t_new, r_new, r_sq;
  logic signed [15:0]     hx, shift_k;
  logic [15:0]            rsh;
  logic [WIDE-1:0]        wide_r, scaled;
  logic                   den_sat;
  logic [OUT_WIDTH-1:0]   den_data;
  state_t                 post_iter;

  always_comb begin
    in_ready = rst_n && !flush &&
               (state_q == S_IDLE || (state_q == S_DONE && out_ready));
    accept   = in_valid && in_ready;
    out_hs   = (state_q == S_DONE) && out_ready && !flush;

    lz       = lzc(x_q);
    s_norm   = lz & ~SW'(1);

    // Newton-Raphson datapath; every product truncated back to Q.FB
    prod_rr  = (2*RW)'(r_q) * (2*RW)'(r_q);
    sq_r     = RW'(prod_rr >> FB);
    prod_mt  = (IN_WIDTH+RW)'(m_q) * (IN_WIDTH+RW)'(t_q);
    mr2      = RW'(prod_mt >> IN_WIDTH);
    t_new    = (mr2 > THREE) ? '0 : THREE - mr2;
    prod_rt  = (2*RW)'(r_q) * (2*RW)'(t_q);
    r_new    = RW'(prod_rt >> (FB + 1));
    prod_mr  = (IN_WIDTH+RW)'(m_q) * (IN_WIDTH+RW)'(r_q);
    r_sq     = RW'(prod_mr >> IN_WIDTH);

    // Output scale: 2^(OUT_FRAC-FB) times 2^(+half_e) for sqrt, 2^(-half_e) for rsqrt
    hx       = {{8{half_e_q[7]}}, half_e_q};
    shift_k  = K_BASE + (op_q ? hx : -hx);
    rsh      = 16'(-shift_k);
    wide_r   = WIDE'(r_q);
    if (!shift_k[15]) scaled = wide_r << shift_k;
    else              scaled = (wide_r + (WIDE'(1) << (rsh - 16'd1))) >> rsh;
    den_sat  = |(scaled >> OUT_WIDTH);
    den_data = den_sat ? '1 : OUT_WIDTH'(scaled);

    post_iter = op_q ? S_SQMUL : S_DENORM;

    state_d = state_q;   iters_d = iters_q;   left_d = left_q;   op_d = op_q;
    out_data_d = out_data_q; out_tag_d = out_tag_q;
    out_sat_d  = out_sat_q;  out_zero_d = out_zero_q;
    x_d = x_q; m_d = m_q; tag_d = tag_q; r_d = r_q; t_d = t_q; half_e_d = half_e_q;
    ops_count_d = ops_count_q + (out_hs ? 32'd1 : 32'd0);
    sat_count_d = sat_count_q + ((out_hs && out_sat_q) ? 32'd1 : 32'd0);

    case (state_q)
      S_IDLE:   if (accept) state_d = S_NORM;
      S_NORM: begin
        if (x_q == '0) begin
          out_data_d = op_q ? '0 : '1;
          out_tag_d  = tag_q;
          out_sat_d  = 1'b0;
          out_zero_d = 1'b1;
          state_d    = S_DONE;
        end else begin
          m_d      = x_q << s_norm;
          half_e_d = 8'((IN_WIDTH - IN_FRAC) / 2) - 8'(s_norm >> 1);
          state_d  = S_LUT;
        end
      end
      S_LUT: begin
        r_d     = SEED_TBL[m_q[IN_WIDTH-1 -: LUT_BITS] * RW +: RW];
        left_d  = iters_q;
        state_d = (iters_q == '0) ? post_iter : S_ITER_A;
      end
      S_ITER_A: begin t_d = sq_r;  state_d = S_ITER_B; end
      S_ITER_B: begin t_d = t_new; state_d = S_ITER_C; end
      S_ITER_C: begin
        r_d     = r_new;
        left_d  = left_q - 1'b1;
        state_d = (left_q == IT_W'(1)) ? post_iter : S_ITER_A;
      end
      S_SQMUL:  begin r_d = r_sq; state_d = S_DENORM; end
      S_DENORM: begin
        out_data_d = den_data;
        out_tag_d  = tag_q;
        out_sat_d  = den_sat;
        out_zero_d = 1'b0;
        state_d    = S_DONE;
      end
      S_DONE:   if (out_ready) state_d = accept ? S_NORM : S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (accept) begin
      x_d     = in_data;
      op_d    = in_op;
      tag_d   = in_tag;
      iters_d = ({1'b0, in_iters} > (IT_W+1)'(MAX_ITERS)) ? IT_W'(MAX_ITERS) : in_iters;
    end

    if (flush) state_d = S_IDLE;
  end

  // ---- control and output registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      iters_q     <= '0;
      left_q      <= '0;
      op_q        <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_sat_q   <= 1'b0;
      out_zero_q  <= 1'b0;
      ops_count_q <= '0;
      sat_count_q <= '0;
    end else begin
      state_q     <= state_d;
      iters_q     <= iters_d;
      left_q      <= left_d;
      op_q        <= op_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      out_sat_q   <= out_sat_d;
      out_zero_q  <= out_zero_d;
      ops_count_q <= ops_count_d;
      sat_count_q <= sat_count_d;
    end
  end

  // ---- datapath registers ----
  always_ff @(posedge clk) begin
    x_q      <= x_d;
    m_q      <= m_d;
    tag_q    <= tag_d;
    r_q      <= r_d;
    t_q      <= t_d;
    half_e_q <= half_e_d;
  end

  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
  assign out_sat   = out_sat_q;
  assign out_zero  = out_zero_q;
  assign ops_count = ops_count_q;
  assign sat_count = sat_count_q;
endmodule

// File: tb/tb_tpu_rsqrt_iter_unit.sv
module tb_tpu_rsqrt_iter_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, in_op, out_ready;
  logic [15:0] in_data;
  logic [1:0]  in_iters;
  logic [3:0]  in_tag;

  logic        a_in_ready, a_out_valid, a_out_sat, a_out_zero, a_busy;
  logic [15:0] a_out_data;
  logic [3:0]  a_out_tag;
  logic [31:0] a_ops, a_sats;
  logic        b_in_ready, b_out_valid, b_out_sat, b_out_zero, b_busy;
  logic [15:0] b_out_data;
  logic [3:0]  b_out_tag;
  logic [31:0] b_ops, b_sats;

  tpu_rsqrt_iter_unit dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_op(in_op), .in_iters(in_iters), .in_tag(in_tag),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data), .out_tag(a_out_tag),
    .out_sat(a_out_sat), .out_zero(a_out_zero), .busy(a_busy),
    .ops_count(a_ops), .sat_count(a_sats));

  tpu_rsqrt_iter_unit #(.OUT_FRAC(12)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_op(in_op), .in_iters(in_iters), .in_tag(in_tag),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data), .out_tag(b_out_tag),
    .out_sat(b_out_sat), .out_zero(b_out_zero), .busy(b_busy),
    .ops_count(b_ops), .sat_count(b_sats));

  int     n_checks = 0;
  int     n_pass   = 0;
  longint ops_m = 0, sats_a_m = 0, sats_b_m = 0;

  task automatic chk(input string tag, input longint obs, input longint exp, input longint tol = 0);
    longint d;
    n_checks++;
    d = obs - exp;
    if (d < 0) d = -d;
    if (d <= tol) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) tol %0d", tag, obs, obs, exp, exp, tol);
  endtask

  // Ideal result from real arithmetic: x = d / 2^8, f = 1/sqrt(x) or sqrt(x)
  function automatic longint ref_val(input int d, input bit op, input int ofrac, output bit sat);
    real    x, f, v;
    longint e;
    sat = 1'b0;
    if (d == 0) return op ? 0 : 65535;
    x = d / 256.0;
    f = op ? $sqrt(x) : 1.0 / $sqrt(x);
    v = f * (2.0 ** ofrac);
    e = longint'($floor(v + 0.5));
    if (e > 65535) begin sat = 1'b1; e = 65535; end
    return e;
  endfunction

  task automatic issue(input logic [15:0] d, input bit op, input logic [1:0] it,
                       input logic [3:0] tag, input string nm);
    int w;
    in_data = d; in_op = op; in_iters = it; in_tag = tag; in_valid = 1'b1;
    w = 0;
    do begin @(negedge clk); w++; end while (!a_in_ready && w < 50);
    if (!a_in_ready) chk({nm, "_accept_timeout"}, 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Starts just after the accept edge; waits for the result, checks it, completes the handshake.
  task automatic collect(input logic [15:0] d, input bit op, input logic [1:0] it,
                         input logic [3:0] tag, input int tol, input string nm);
    int     lat, exp_lat;
    longint ea, eb;
    bit     sa, sb;
    ea = ref_val(int'(d), op, 11, sa);
    eb = ref_val(int'(d), op, 12, sb);
    exp_lat = (d == 0) ? 2 : 4 + 3*int'(it) + int'(op);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!a_out_valid && lat < 100);
    chk({nm, "_lat"}, lat, exp_lat);
    chk({nm, "_tag"}, a_out_tag, tag);
    chk({nm, "_zero"}, a_out_zero, (d == 0));
    chk({nm, "_sat"}, a_out_sat, sa);
    chk({nm, "_bsat"}, b_out_sat, sb);
    if (tol >= 0) begin
      chk({nm, "_data"}, a_out_data, ea, (d == 0) ? 0 : tol);
      chk({nm, "_bdata"}, b_out_data, eb, (sb || d == 0) ? 0 : 2);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    ops_m++;
    if (sa) sats_a_m++;
    if (sb) sats_b_m++;
    chk({nm, "_ops"}, a_ops, ops_m);
    chk({nm, "_sats"}, a_sats, sats_a_m);
    chk({nm, "_bsats"}, b_sats, sats_b_m);
  endtask

  task automatic run_op(input logic [15:0] d, input bit op, input logic [1:0] it,
                        input logic [3:0] tag, input int tol, input string nm);
    issue(d, op, it, tag, nm);
    collect(d, op, it, tag, tol, nm);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_valid"}, a_out_valid, 0);
    chk({nm, "_ready"}, a_in_ready, 0);
    chk({nm, "_busy"}, a_busy, 0);
    chk({nm, "_data"}, a_out_data, 0);
    chk({nm, "_tag"}, a_out_tag, 0);
    chk({nm, "_flags"}, {a_out_sat, a_out_zero}, 0);
    chk({nm, "_ops"}, a_ops, 0);
    chk({nm, "_sats"}, a_sats, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] d;
    bit          op;
    logic [1:0]  it;
    int          cnt;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = 1'b0; out_ready = 1'b1;
    in_data = '0; in_iters = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst0_ready_after", a_in_ready, 1);
    @(posedge clk); #1;

    // Directed values
    run_op(16'h0100, 1'b0, 2'd3, 4'h1, 0, "x1_rsqrt");
    chk("x1_rsqrt_const", a_out_data, 16'h0800);
    run_op(16'h0400, 1'b0, 2'd3, 4'h2, 0, "x4_rsqrt");
    chk("x4_rsqrt_const", a_out_data, 16'h0400);
    run_op(16'h0400, 1'b1, 2'd3, 4'h3, 0, "x4_sqrt");
    chk("x4_sqrt_const", a_out_data, 16'h1000);
    run_op(16'h0001, 1'b0, 2'd3, 4'h4, 2, "xmin_rsqrt");
    chk("xmin_rsqrt_const", a_out_data, 16'h8000, 2);
    chk("xmin_b_sat_data", b_out_data, 16'hFFFF);
    chk("xmin_b_sat_flag", b_out_sat, 1);
    run_op(16'h0000, 1'b0, 2'd3, 4'h5, 0, "zero_rsqrt");
    run_op(16'h0000, 1'b1, 2'd3, 4'h6, 0, "zero_sqrt");
    chk("zero_sqrt_const", a_out_data, 16'h0000);
    run_op(16'hFFFF, 1'b1, 2'd3, 4'h7, 2, "xmax_sqrt");

    // Output stall followed by back-to-back accept
    out_ready = 1'b0;
    issue(16'h0400, 1'b1, 2'd3, 4'h5, "stall");
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!a_out_valid && cnt < 100);
    chk("stall_lat", cnt, 14);
    in_data = 16'h0100; in_op = 1'b0; in_iters = 2'd3; in_tag = 4'h6; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      chk("stall_valid", a_out_valid, 1);
      chk("stall_data", a_out_data, 16'h1000);
      chk("stall_tag", a_out_tag, 4'h5);
      chk("stall_in_ready", a_in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", a_in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    ops_m++;
    chk("b2b_valid_drop", a_out_valid, 0);
    chk("b2b_busy", a_busy, 1);
    chk("b2b_ops", a_ops, ops_m);
    collect(16'h0100, 1'b0, 2'd3, 4'h6, 0, "b2b");

    // Flush during ITER_B
    issue(16'h1234, 1'b0, 2'd3, 4'h9, "flush");
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready_low", a_in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_valid", a_out_valid, 0);
    chk("flush_busy", a_busy, 0);
    @(negedge clk);
    chk("flush_in_ready", a_in_ready, 1);
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (a_out_valid) cnt++;
    end
    chk("flush_no_output", cnt, 0);
    chk("flush_ops", a_ops, ops_m);
    @(posedge clk); #1;

    // Reset during ITER_C
    issue(16'h0321, 1'b1, 2'd3, 4'hA, "rstmid");
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rstmid");
    ops_m = 0; sats_a_m = 0; sats_b_m = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_ready_after", a_in_ready, 1);
    @(posedge clk); #1;
    run_op(16'h0100, 1'b0, 2'd3, 4'hB, 0, "post_rst");

    // Randomised operands against the real-arithmetic model
    for (int n = 0; n < 40; n++) begin
      d  = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom_range(2, 65535));
      op = 1'($urandom_range(0, 1));
      it = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'd3;
      run_op(d, op, it, 4'($urandom_range(0, 15)), (it == 2'd3) ? 2 : -1, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
